// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: CSR indices, operation
// encodings, mstatus/mip bit positions and trap cause codes.
package csr_pkg;

  localparam logic [3:0] CSR_IDX_MSTATUS  = 4'd1;
  localparam logic [3:0] CSR_IDX_MIE      = 4'd2;
  localparam logic [3:0] CSR_IDX_MTVEC    = 4'd3;
  localparam logic [3:0] CSR_IDX_MEPC     = 4'd4;
  localparam logic [3:0] CSR_IDX_MCAUSE   = 4'd5;
  localparam logic [3:0] CSR_IDX_MIP      = 4'd6;
  localparam logic [3:0] CSR_IDX_UNMAPPED = 4'd15;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } csr_state_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIP_MTIP = 7;

  // The interrupt flag of mcause is the top bit, i.e. XLEN-1 of the core.
  localparam int MCAUSE_ECALL_M = 11;
  localparam int MCAUSE_MTI     = 7;

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage plus a two-state trap sequencer that performs
// ecall / timer-interrupt / mret side effects and emits a one-cycle redirect.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      csr_map_num,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            ecall,
  input  logic            mret,
  input  logic            intr_take,
  input  logic [XLEN-1:0] pc,
  input  logic            irq_timer,
  output logic            intr_pending,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            mtip_q, mtip_d;
  logic [XLEN-1:0] redirPc_q, redirPc_d;
  csr_state_e      state_q, state_d;

  logic [XLEN-1:0] mipView;
  logic [XLEN-1:0] newVal;
  logic            csrWe;

  // Applies the RW/RS/RC operation to the old value, then the per-CSR WARL masks.
  function automatic logic [XLEN-1:0] csrWriteValue(
    input logic [3:0]      idx,
    input logic [1:0]      op,
    input logic [XLEN-1:0] oldVal,
    input logic [XLEN-1:0] wdata
  );
    logic [XLEN-1:0] v;
    case (op)
      CSR_OP_RW: v = wdata;
      CSR_OP_RS: v = oldVal | wdata;
      CSR_OP_RC: v = oldVal & ~wdata;
      default:   v = oldVal;
    endcase
    case (idx)
      CSR_IDX_MSTATUS: v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      CSR_IDX_MTVEC:   v[1:0] = 2'b00;
      CSR_IDX_MEPC:    v[0] = 1'b0;
      default:         ;
    endcase
    return v;
  endfunction

  assign mipView = XLEN'(mtip_q) << MIP_MTIP;

  always_comb begin
    csr_rdata = '0;
    case (csr_map_num)
      CSR_IDX_MSTATUS: csr_rdata = mstatus_q;
      CSR_IDX_MIE:     csr_rdata = mie_q;
      CSR_IDX_MTVEC:   csr_rdata = mtvec_q;
      CSR_IDX_MEPC:    csr_rdata = mepc_q;
      CSR_IDX_MCAUSE:  csr_rdata = mcause_q;
      CSR_IDX_MIP:     csr_rdata = mipView;
      default:         csr_rdata = '0;
    endcase
  end

  assign csr_illegal = (csr_op != CSR_OP_NONE) &&
                       !((csr_map_num >= CSR_IDX_MSTATUS) && (csr_map_num <= CSR_IDX_MIP));
  assign csrWe  = (csr_op != CSR_OP_NONE) && !csr_illegal;
  assign newVal = csrWriteValue(csr_map_num, csr_op, csr_rdata, csr_wdata);

  // Masking with state_q keeps the core from nesting a trap in the flush cycle.
  assign intr_pending   = (state_q == ST_RUN) && mstatus_q[MSTATUS_MIE] &&
                          mie_q[MIP_MTIP] && mtip_q;
  assign redirect_valid = (state_q == ST_REDIR);
  assign redirect_pc    = redirPc_q;

  always_comb begin
    mstatus_d = mstatus_q;
    mie_d     = mie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mtip_d    = irq_timer;
    redirPc_d = redirPc_q;
    state_d   = state_q;

    case (state_q)
      ST_RUN: begin
        if (intr_take || ecall) begin
          mepc_d   = pc & ~XLEN'(1);
          mcause_d = intr_take ? {1'b1, {(XLEN-5){1'b0}}, 4'(MCAUSE_MTI)}
                               : XLEN'(MCAUSE_ECALL_M);
          mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
          mstatus_d[MSTATUS_MIE]  = 1'b0;
          redirPc_d = mtvec_q & ~XLEN'(3);
          state_d   = ST_REDIR;
        end else if (mret) begin
          mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
          mstatus_d[MSTATUS_MPIE] = 1'b1;
          redirPc_d = mepc_q;
          state_d   = ST_REDIR;
        end else if (csrWe) begin
          case (csr_map_num)
            CSR_IDX_MSTATUS: mstatus_d = newVal;
            CSR_IDX_MIE:     mie_d     = newVal;
            CSR_IDX_MTVEC:   mtvec_d   = newVal;
            CSR_IDX_MEPC:    mepc_d    = newVal;
            CSR_IDX_MCAUSE:  mcause_d  = newVal;
            default:         ;
          endcase
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q <= MSTATUS_RST;
      mie_q     <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtip_q    <= 1'b0;
      redirPc_q <= '0;
      state_q   <= ST_RUN;
    end else begin
      mstatus_q <= mstatus_d;
      mie_q     <= mie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mtip_q    <= mtip_d;
      redirPc_q <= redirPc_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: CSR access, masks, ecall/mret/interrupt
// sequencing, priority and reset during the redirect cycle.
module tb_csr_regfile;

  localparam int XLEN = 64;
  localparam logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      csr_map_num;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            ecall;
  logic            mret;
  logic            intr_take;
  logic [XLEN-1:0] pc;
  logic            irq_timer;
  logic            intr_pending;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  csr_regfile #(.XLEN(XLEN), .MSTATUS_RST(MSTATUS_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_map_num(csr_map_num), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .ecall(ecall), .mret(mret), .intr_take(intr_take), .pc(pc),
    .irq_timer(irq_timer), .intr_pending(intr_pending),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] idx, input logic [1:0] op, input logic [63:0] wdata);
    csr_map_num = idx;
    csr_op      = op;
    csr_wdata   = wdata;
  endtask

  task automatic expectCsr(input string tag, input logic [3:0] idx, input logic [63:0] exp);
    applyStimulus(idx, 2'b00, '0);
    #1;
    checkOutput(tag, csr_rdata, exp);
  endtask

  logic [63:0] resetVals [1:6];

  initial begin
    resetVals[1] = MSTATUS_RST;
    for (int i = 2; i <= 6; i++) resetVals[i] = '0;

    rst_n = 1'b0;
    ecall = 0; mret = 0; intr_take = 0; irq_timer = 0; pc = '0;
    applyStimulus(4'd0, 2'b00, '0);
    #3;
    checkOutput("rst_redir_valid", 64'(redirect_valid), 64'd0);
    checkOutput("rst_redir_pc", redirect_pc, 64'd0);
    checkOutput("rst_intr_pending", 64'(intr_pending), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 1; i <= 6; i++) expectCsr($sformatf("rst_csr%0d", i), 4'(i), resetVals[i]);

    // Unmapped write: illegal, reads zero, changes nothing
    applyStimulus(4'd15, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    checkOutput("unmapped_illegal", 64'(csr_illegal), 64'd1);
    checkOutput("unmapped_rdata", csr_rdata, 64'd0);
    tick();
    expectCsr("unmapped_nochg_mstatus", 4'd1, MSTATUS_RST);
    expectCsr("unmapped_nochg_mtvec", 4'd3, 64'd0);

    applyStimulus(4'd3, 2'b01, 64'h8000_0103);
    #1;
    checkOutput("mtvec_legal", 64'(csr_illegal), 64'd0);
    tick();
    expectCsr("mtvec_mask", 4'd3, 64'h8000_0100);

    applyStimulus(4'd2, 2'b10, 64'h80); tick();
    expectCsr("mie_rs", 4'd2, 64'h80);
    applyStimulus(4'd2, 2'b11, 64'h80); tick();
    expectCsr("mie_rc", 4'd2, 64'h0);

    applyStimulus(4'd1, 2'b10, 64'h8); tick();
    expectCsr("mstatus_set_mie", 4'd1, 64'h0000_000a_0000_1808);
    applyStimulus(4'd1, 2'b11, 64'h1800); tick();
    expectCsr("mstatus_mpp_hard", 4'd1, 64'h0000_000a_0000_1808);

    applyStimulus(4'd4, 2'b01, 64'h8000_0003); tick();
    expectCsr("mepc_mask", 4'd4, 64'h8000_0002);

    // ecall
    pc = 64'h8000_0010; ecall = 1;
    tick();
    ecall = 0;
    checkOutput("ecall_valid", 64'(redirect_valid), 64'd1);
    checkOutput("ecall_pc", redirect_pc, 64'h8000_0100);
    expectCsr("ecall_mepc", 4'd4, 64'h8000_0010);
    expectCsr("ecall_mcause", 4'd5, 64'd11);
    expectCsr("ecall_mstatus", 4'd1, 64'h0000_000a_0000_1880);
    tick();
    checkOutput("ecall_pulse_end", 64'(redirect_valid), 64'd0);

    // mret
    mret = 1;
    tick();
    mret = 0;
    checkOutput("mret_valid", 64'(redirect_valid), 64'd1);
    checkOutput("mret_pc", redirect_pc, 64'h8000_0010);
    expectCsr("mret_mstatus", 4'd1, 64'h0000_000a_0000_1888);
    tick();
    checkOutput("mret_pulse_end", 64'(redirect_valid), 64'd0);

    // Timer interrupt
    applyStimulus(4'd2, 2'b10, 64'h80);
    irq_timer = 1;
    tick();
    applyStimulus(4'd6, 2'b01, 64'h0); tick();
    expectCsr("mip_readonly", 4'd6, 64'h80);
    checkOutput("intr_pending_on", 64'(intr_pending), 64'd1);
    pc = 64'h8000_0200; intr_take = 1;
    tick();
    intr_take = 0; ecall = 1; pc = 64'h8000_0400;
    checkOutput("intr_valid", 64'(redirect_valid), 64'd1);
    #1;
    checkOutput("intr_pending_redir", 64'(intr_pending), 64'd0);
    expectCsr("intr_mcause", 4'd5, 64'h8000_0000_0000_0007);
    expectCsr("intr_mepc", 4'd4, 64'h8000_0200);
    expectCsr("intr_mstatus", 4'd1, 64'h0000_000a_0000_1880);
    tick();
    ecall = 0;
    checkOutput("redir_ecall_ignored", 64'(redirect_valid), 64'd0);
    expectCsr("redir_ecall_mcause", 4'd5, 64'h8000_0000_0000_0007);
    expectCsr("redir_ecall_mepc", 4'd4, 64'h8000_0200);
    irq_timer = 0;
    tick();

    // ecall beats a simultaneous CSR write
    applyStimulus(4'd4, 2'b01, 64'h1234);
    pc = 64'h8000_0301; ecall = 1;
    tick();
    ecall = 0;
    applyStimulus(4'd0, 2'b00, '0);
    checkOutput("prio_valid", 64'(redirect_valid), 64'd1);
    expectCsr("prio_mepc", 4'd4, 64'h8000_0300);

    // Asynchronous reset inside the redirect cycle
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(redirect_valid), 64'd0);
    checkOutput("arst_pc", redirect_pc, 64'd0);
    for (int i = 1; i <= 6; i++) expectCsr($sformatf("arst_csr%0d", i), 4'(i), resetVals[i]);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_valid", 64'(redirect_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR storage and trap sequencer for the single-issue core.
- Consumes the 4-bit CSR index produced by the CSR address decoder. Executes CSRRW/CSRRS/CSRRC reads and writes.
- Performs the architectural side effects of ecall, timer-interrupt entry and mret, then issues a one-cycle registered PC redirect to the fetch stage.

Parameters:
- XLEN, 64, register and PC width.
- MSTATUS_RST, 64'h0000_000a_0000_1800, mstatus reset value (UXL/SXL=2, MPP=3).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_map_num  in  4  decoded CSR index: 1 mstatus, 2 mie, 3 mtvec, 4 mepc, 5 mcause, 6 mip, 15 unmapped
- csr_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
- csr_wdata  in  XLEN  rs1 value or zero-extended zimm
- csr_rdata  out  XLEN  current value of indexed CSR (combinational)
- csr_illegal  out  1  csr_op!=0 and index not in 1..6
- ecall  in  1  environment call retiring this cycle
- mret  in  1  mret retiring this cycle
- intr_take  in  1  core accepts pending timer interrupt at this instruction boundary
- pc  in  XLEN  PC of retiring instruction (ecall) or next PC (interrupt)
- irq_timer  in  1  level timer interrupt from CLINT
- intr_pending  out  1  mstatus.MIE & mie.MTIE & mip.MTIP
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (async, rst_n=0): mstatus=MSTATUS_RST; mie, mtvec, mepc, mcause = 0; mip.MTIP=0; FSM=RUN; redirect_valid=0; redirect_pc=0.
- Reads: csr_rdata reflects the pre-write value in the same cycle. Unmapped index reads 0. Writes land on the rising edge and are visible the next cycle.
- Write value: RW -> wdata; RS -> old | wdata; RC -> old & ~wdata. Write is suppressed when csr_illegal=1 or the FSM is in REDIR.
- Write masks:
  - mtvec[1:0] forced 0 (direct mode only).
  - mepc[0] forced 0.
  - mip: only bit7 is implemented and it is read-only. It is sampled from irq_timer every cycle and software writes are ignored.
  - mstatus: MPP is hardwired to 2'b11.
- FSM, two states:
  - RUN: redirect_valid=0. A trap (ecall or intr_take) or mret moves to REDIR.
  - REDIR: redirect_valid=1 for exactly one cycle. All inputs (csr_op, ecall, mret, intr_take) are ignored. Unconditionally returns to RUN.
- Trap entry (RUN, ecall|intr_take), on the same edge:
  - mepc <= pc & ~1.
  - mcause <= 11 for ecall; {1'b1, 59'b0, 4'd7} for interrupt.
  - MPIE <= MIE; MIE <= 0.
  - redirect_pc <= mtvec & ~3.
- mret (RUN): MIE <= MPIE; MPIE <= 1; redirect_pc <= mepc.
- Priority:
  - intr_take > ecall > mret > CSR write.
  - A CSR write in the same cycle as a trap or mret is dropped.
  - If ecall and intr_take are both set, interrupt cause is recorded.
- Redirect latency: exactly 1 cycle from the retiring event to redirect_valid.
- intr_pending: combinational from registered state. It is 0 during REDIR, so the core cannot take a nested interrupt in the flush cycle.
- Reset mid-REDIR: redirect_valid drops immediately (asynchronously). No side effect is replayed.

Decomposition:
- Shared package csr_pkg holds:
  - CSR index constants (1..6, 15).
  - csr_op encodings.
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - mcause constants (ECALL_M=11, MTI=7, INTR bit = XLEN-1).
  - MIP_MTIP=7.
- Reuse the existing CSR address decoder upstream; no new sub-module.
- Write-value/mask computation is a local function, not a separate module.

Test Plan:
- Reset then read indices 1..6 -> rdata 0x0000000a00001800, 0, 0, 0, 0, 0. Index 15 with op=RW -> csr_illegal=1, rdata=0, no state change.
- RW mtvec 0x80000103, then read -> 0x80000100. RS mie 0x80 then RC mie 0x80 -> reads 0x80 then 0x0.
- mstatus.MIE=1, mtvec=0x80000100, ecall with pc=0x80000010:
  - Next cycle: redirect_valid=1, redirect_pc=0x80000100, mepc=0x80000010, mcause=11, mstatus MIE=0 MPIE=1.
  - Following cycle: redirect_valid=0.
- mret after the above -> redirect_pc=0x80000010, MIE=1, MPIE=1, single-cycle pulse.
- MIE=1, mie=0x80, irq_timer=1 -> intr_pending=1 and mip reads 0x80. intr_take with pc=0x80000200 -> mcause=0x8000000000000007, mepc=0x80000200. During REDIR, intr_pending=0 and a simultaneous ecall is ignored.
- ecall and csr_op=RW to mepc with wdata=0x1234 in the same cycle -> mepc=pc, the write is dropped. Assert rst_n low during REDIR -> redirect_valid=0 immediately, all CSRs at reset values.
